// File: rtl/mem_sys_top.sv
// Bit-serial banked X (activation) and W (weight) storage with a shared write-data bit.
// Each memory has a registered 1-cycle read port that holds its value while writing.
module mem_sys_top #(
  parameter int unsigned X_DEPTH = 1024,
  parameter int unsigned W_DEPTH = 4096,
  parameter int unsigned N_BANKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_x,
  input  logic        we_w,
  input  logic        data_in,
  input  logic [9:0]  address_x,
  input  logic [19:0] address_w,
  input  logic [1:0]  sel_x,
  input  logic [1:0]  sel_w,
  output logic        data_out_x,
  output logic        data_out_w
);

  localparam int unsigned XAW = $clog2(X_DEPTH);
  localparam int unsigned WAW = $clog2(W_DEPTH);

  logic x_mem [N_BANKS][X_DEPTH];
  logic w_mem [N_BANKS][W_DEPTH];

  logic           x_in_range;
  logic           w_in_range;
  logic [XAW-1:0] x_idx;
  logic [WAW-1:0] w_idx;

  // Range is checked on the full address; the index is only meaningful when in range.
  always_comb begin
    x_in_range = (32'(address_x) < X_DEPTH);
    w_in_range = (32'(address_w) < W_DEPTH);
    x_idx      = address_x[XAW-1:0];
    w_idx      = address_w[WAW-1:0];
  end

  always_ff @(posedge clk) begin
    if (we_x && x_in_range)
      x_mem[sel_x][x_idx] <= data_in;
    if (we_w && w_in_range)
      w_mem[sel_w][w_idx] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_x <= 1'b0;
      data_out_w <= 1'b0;
    end else begin
      if (!we_x)
        data_out_x <= x_in_range ? x_mem[sel_x][x_idx] : 1'b0;
      if (!we_w)
        data_out_w <= w_in_range ? w_mem[sel_w][w_idx] : 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_sys_top.sv
// Directed self-checking bench for mem_sys_top with hand-computed expected values.
module tb_mem_sys_top;

  logic        clk;
  logic        rst;
  logic        we_x;
  logic        we_w;
  logic        data_in;
  logic [9:0]  address_x;
  logic [19:0] address_w;
  logic [1:0]  sel_x;
  logic [1:0]  sel_w;
  logic        data_out_x;
  logic        data_out_w;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_sys_top #(
    .X_DEPTH(1024),
    .W_DEPTH(4096),
    .N_BANKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .we_x(we_x),
    .we_w(we_w),
    .data_in(data_in),
    .address_x(address_x),
    .address_w(address_w),
    .sel_x(sel_x),
    .sel_w(sel_w),
    .data_out_x(data_out_x),
    .data_out_w(data_out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic drive(input logic wx, input logic ww, input logic d,
                       input logic [9:0] ax, input logic [19:0] aw,
                       input logic [1:0] sx, input logic [1:0] sw);
    @(negedge clk);
    we_x      = wx;
    we_w      = ww;
    data_in   = d;
    address_x = ax;
    address_w = aw;
    sel_x     = sx;
    sel_w     = sw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    we_x      = 1'b0;
    we_w      = 1'b0;
    data_in   = 1'b0;
    address_x = '0;
    address_w = '0;
    sel_x     = '0;
    sel_w     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_x", data_out_x, 1'b0);
    check("reset_w", data_out_w, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential writes then reads in bank 2
    drive(1'b1, 1'b0, 1'b1, 10'd0, 20'd0, 2'd2, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 10'd1, 20'd0, 2'd2, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 10'd2, 20'd0, 2'd2, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 20'd0, 2'd2, 2'd0);
    check("seq_rd0", data_out_x, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 10'd1, 20'd0, 2'd2, 2'd0);
    check("seq_rd1", data_out_x, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'd2, 20'd0, 2'd2, 2'd0);
    check("seq_rd2", data_out_x, 1'b1);

    // Bank isolation at the same address
    drive(1'b1, 1'b0, 1'b1, 10'd5, 20'd0, 2'd2, 2'd0);
    drive(1'b1, 1'b0, 1'b0, 10'd5, 20'd0, 2'd1, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 10'd5, 20'd0, 2'd2, 2'd0);
    check("iso_b2", data_out_x, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 10'd5, 20'd0, 2'd1, 2'd0);
    check("iso_b1", data_out_x, 1'b0);

    // Simultaneous write to both memories, W at its top address
    drive(1'b1, 1'b1, 1'b1, 10'd7, 20'd4095, 2'd3, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 10'd7, 20'd4095, 2'd3, 2'd0);
    check("dual_x", data_out_x, 1'b1);
    check("dual_w", data_out_w, 1'b1);

    // Asynchronous reset pulse mid-cycle with both outputs at 1
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_x", data_out_x, 1'b0);
    check("async_rst_w", data_out_w, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range W accesses
    drive(1'b0, 1'b1, 1'b0, 10'd0, 20'd0, 2'd0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 20'd4095, 2'd0, 2'd0);
    check("w_rd4095", data_out_w, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 10'd0, 20'd4096, 2'd0, 2'd0);
    check("w_hold_oor_wr", data_out_w, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 20'd0, 2'd0, 2'd0);
    check("w_oor_wr_ignored", data_out_w, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 20'd4095, 2'd0, 2'd0);
    check("w_rd4095_again", data_out_w, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 20'd4096, 2'd0, 2'd0);
    check("w_oor_rd4096", data_out_w, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 20'd4095, 2'd0, 2'd0);
    check("w_rd4095_third", data_out_w, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 10'd0, 20'd8191, 2'd0, 2'd0);
    check("w_oor_rd8191", data_out_w, 1'b0);

    // Output holds while writing
    drive(1'b1, 1'b0, 1'b1, 10'd9, 20'd0, 2'd0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 10'd9, 20'd0, 2'd0, 2'd0);
    check("hold_pre", data_out_x, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 10'd9, 20'd0, 2'd0, 2'd0);
    check("hold_during_wr", data_out_x, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 10'd9, 20'd0, 2'd0, 2'd0);
    check("hold_post", data_out_x, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
